// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame marker,
// data width and FSM state encodings.
package imem_loader_pkg;

  localparam int         INST_WIDTH    = 32;
  localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LEN_LO = 3'd1,
    LDR_LEN_HI = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_CSUM   = 3'd4,
    LDR_DONE   = 3'd5,
    LDR_ERR    = 3'd6
  } ldr_state_e;

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader: packs little-endian bytes into 32-bit words,
// writes them to imem and releases core reset after a valid checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH_WORDS = 256,
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] SYNC_BYTE   = LDR_SYNC_BYTE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_we,
  output logic [ADDR_W-1:0]     o_waddr,
  output logic [INST_WIDTH-1:0] o_wdata,
  output logic                  o_core_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

  ldr_state_e            state_q, state_d;
  logic                  rx_ready_q;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            sum_q, sum_d;
  logic [INST_WIDTH-1:0] word_q, word_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [INST_WIDTH-1:0] wdata_q, wdata_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;
  logic [INST_WIDTH-1:0] word_shift;
  logic [7:0]            sum_next;
  logic [15:0]           len_full;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign accept     = i_rx_valid && rx_ready_q;
  assign word_shift = {i_rx_data, word_q[INST_WIDTH-1:8]};
  assign sum_next   = csum_add(sum_q, i_rx_data);
  assign len_full   = {i_rx_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sum_d      = sum_q;
    word_d     = word_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = 1'b0;
    error_d    = error_q;
    if (accept) begin
      case (state_q)
        LDR_IDLE, LDR_DONE, LDR_ERR: begin
          if (i_rx_data == SYNC_BYTE) begin
            state_d    = LDR_LEN_LO;
            error_d    = 1'b0;
            core_rst_d = 1'b1;
            sum_d      = 8'h00;
          end
        end
        LDR_LEN_LO: begin
          len_d   = {8'h00, i_rx_data};
          sum_d   = sum_next;
          state_d = LDR_LEN_HI;
        end
        LDR_LEN_HI: begin
          len_d      = len_full;
          sum_d      = sum_next;
          addr_d     = '0;
          word_cnt_d = 16'd0;
          byte_cnt_d = 2'd0;
          if (len_full > DEPTH_N) begin
            state_d = LDR_ERR;
            error_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = LDR_CSUM;
          end else begin
            state_d = LDR_DATA;
          end
        end
        LDR_DATA: begin
          sum_d      = sum_next;
          word_d     = word_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes the word; the write goes out on the next cycle.
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = word_shift;
            waddr_d    = addr_q;
            addr_d     = addr_q + ADDR_W'(4);
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == len_q) state_d = LDR_CSUM;
          end
        end
        LDR_CSUM: begin
          if (sum_next == 8'h00) begin
            state_d    = LDR_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = LDR_ERR;
            error_d = 1'b1;
          end
        end
        default: state_d = LDR_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= LDR_IDLE;
      rx_ready_q <= 1'b0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      sum_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= 1'b1;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sum_q      <= sum_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign o_rx_ready = rx_ready_q;
  assign o_we       = we_q;
  assign o_waddr    = waddr_q;
  assign o_wdata    = wdata_q;
  assign o_core_rst = core_rst_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_busy     = !(state_q == LDR_IDLE || state_q == LDR_DONE || state_q == LDR_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte and expected
// imem writes are queued, then matched against o_we/o_waddr/o_wdata.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  int n_assert = 0;
  int n_fail   = 0;
  logic [41:0] exp_q[$];
  logic [31:0] words[256];
  int cyc = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  bit chk_space = 1'b0;
  int last_we = -1;
  int w0, d0;

  imem_loader #(.DEPTH_WORDS(256), .ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_rx_ready(rx_ready), .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
    .o_core_rst(core_rst), .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe pops one expected {addr, data}.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (we) begin
        logic [41:0] e;
        we_cnt++;
        check("write_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("waddr", 64'(waddr), 64'(e[41:32]));
          check("wdata", 64'(wdata), 64'(e[31:0]));
        end
        if (chk_space && last_we >= 0) check("we_spacing", 64'(cyc - last_we), 64'(4));
        last_we = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] cdelta);
    logic [7:0]  sum;
    logic [15:0] len;
    logic [7:0]  bt;
    logic [31:0] w;
    sum = 8'h00;
    len = 16'(n);
    send_byte(8'hA5);
    sum = sum + len[7:0];
    send_byte(len[7:0]);
    sum = sum + len[15:8];
    send_byte(len[15:8]);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        bt  = w[8*b +: 8];
        sum = sum + bt;
        if (b == 3) exp_q.push_back({10'(i * 4), w});
        send_byte(bt);
      end
    end
    send_byte(8'(8'h00 - sum) + cdelta);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(rx_ready), 64'(0));
    check({tag, "_we"}, 64'(we), 64'(0));
    check({tag, "_waddr"}, 64'(waddr), 64'(0));
    check({tag, "_wdata"}, 64'(wdata), 64'(0));
    check({tag, "_core_rst"}, 64'(core_rst), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(rx_ready), 64'(1));

    // 1: nominal two-word frame
    words[0] = 32'h00000013; words[1] = 32'h00100093;
    w0 = we_cnt;
    send_frame(2, 8'h00);
    check("t1_done", 64'(done), 64'(1));
    check("t1_core_rst", 64'(core_rst), 64'(0));
    check("t1_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'(0));
    check("t1_writes", 64'(we_cnt - w0), 64'(2));

    // 2: bad checksum, then recovery
    d0 = done_cnt; w0 = we_cnt;
    send_frame(2, 8'h01);
    check("t2_error", 64'(error), 64'(1));
    check("t2_core_rst", 64'(core_rst), 64'(1));
    @(negedge clk);
    check("t2_no_done", 64'(done_cnt - d0), 64'(0));
    check("t2_writes", 64'(we_cnt - w0), 64'(2));
    words[0] = 32'hDEADBEEF;
    send_frame(1, 8'h00);
    check("t2_error_clr", 64'(error), 64'(0));
    check("t2_done", 64'(done), 64'(1));
    check("t2_core_rst_rel", 64'(core_rst), 64'(0));

    // 3: oversize length
    w0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    check("t3_error", 64'(error), 64'(1));
    check("t3_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)));
    check("t3_no_writes", 64'(we_cnt - w0), 64'(0));
    check("t3_error_held", 64'(error), 64'(1));
    check("t3_core_rst", 64'(core_rst), 64'(1));

    // 4: garbage before sync
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("t4_garbage_busy", 64'(busy), 64'(0));
    check("t4_error_kept", 64'(error), 64'(1));
    send_byte(8'hA5);
    check("t4_busy", 64'(busy), 64'(1));
    check("t4_error_clr", 64'(error), 64'(0));
    rst = 1'b0;
    w0 = we_cnt;
    words[0] = 32'hCAFEF00D;
    // sync already consumed above; feed remaining frame bytes directly
    send_byte(8'h01); send_byte(8'h00);
    exp_q.push_back({10'h000, 32'hCAFEF00D});
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    send_byte(8'(8'h00 - (8'h01 + 8'h0D + 8'hF0 + 8'hFE + 8'hCA)));
    check("t4_done", 64'(done), 64'(1));
    check("t4_writes", 64'(we_cnt - w0), 64'(1));

    // 5: full-depth frame, byte every cycle
    for (int i = 0; i < 256; i++) words[i] = (32'(i) * 32'h01030507) ^ 32'hA5A55A5A;
    w0 = we_cnt; chk_space = 1'b1; last_we = -1;
    send_frame(256, 8'h00);
    check("t5_done", 64'(done), 64'(1));
    chk_space = 1'b0;
    check("t5_writes", 64'(we_cnt - w0), 64'(256));
    check("t5_last_addr", 64'(waddr), 64'(10'h3FC));
    check("t5_queue_empty", 64'(exp_q.size()), 64'(0));

    // 6: reset mid-frame, then clean reload
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h77); send_byte(8'h66);
    check("t6_busy", 64'(busy), 64'(1));
    check("t6_core_rst", 64'(core_rst), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("t6_reset");
    rst = 1'b0;
    @(negedge clk);
    words[0] = 32'h12345678; words[1] = 32'h9ABCDEF0;
    w0 = we_cnt;
    send_frame(2, 8'h00);
    check("t6_done", 64'(done), 64'(1));
    check("t6_writes", 64'(we_cnt - w0), 64'(2));
    @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
